// File: rtl/dkongjr_vram_arb_pkg.sv
// Shared types and constants for the Donkey Kong Jr tile-VRAM arbiter.
// Contents: arbiter state enum, address/data widths, default video slot phase,
// and the helper that builds the tile-fetch address from the beam counters.
package dkongjr_vram_arb_pkg;

  localparam int AW = 10;
  localparam int DW = 8;

  localparam logic [3:0] VID_SLOT_DEF = 4'hC;

  typedef enum logic [2:0] {
    IDLE,
    CPU_ISSUE,
    CPU_DONE,
    HS_ISSUE,
    HS_DONE
  } arb_state_t;

  // Row comes from the flipped vertical counter (8-pixel rows), column from
  // H_CNT[8:4]; under flip the column runs right-to-left.
  function automatic logic [AW-1:0] vid_addr(input logic [7:0] vf,
                                              input logic [9:0] h,
                                              input logic       flip);
    return {vf[7:3], h[8:4] ^ {5{flip}}};
  endfunction

endpackage

// File: rtl/dkongjr_arb_age.sv
// Saturating starvation counter for the hiscore requester.
// Ports: clk/rst (sync, active high), clr and inc controls, at_max flag.
// Counts up to MAX and holds there; clr has priority over inc.
module dkongjr_arb_age #(
  parameter logic [3:0] MAX = 4'd8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (clr) begin
      cnt <= 4'd0;
    end else if (inc && (cnt != MAX)) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign at_max = (cnt == MAX);

endmodule

// File: rtl/dkongjr_vram_arb.sv
// Single-port tile VRAM arbiter: video fetch (fixed slot) > CPU (WAIT-stretched) > hiscore DMA.
// Ports: beam counters/flip/blank in, Z80 bus in/out with WAITn, hiscore req/ack port,
// VRAM macro pins, and the fetched tile code with its valid pulse.
module dkongjr_vram_arb
  import dkongjr_vram_arb_pkg::*;
#(
  parameter logic [3:0] VID_SLOT       = VID_SLOT_DEF,
  parameter bit         CPU_BLOCK_DISP = 1'b1,
  parameter int         HS_MAX_WAIT    = 8
) (
  input  logic          CLK_12M,
  input  logic          I_RESET,
  input  logic [9:0]    I_H_CNT,
  input  logic [7:0]    I_VF_CNT,
  input  logic          I_FLIP,
  input  logic          I_CMPBLK,
  input  logic [AW-1:0] I_AB,
  input  logic [DW-1:0] I_DB,
  input  logic          I_VRAM_WRn,
  input  logic          I_VRAM_RDn,
  output logic [DW-1:0] O_DB,
  output logic          O_CPU_WAITn,
  input  logic          I_HS_REQ,
  input  logic          I_HS_WE,
  input  logic [AW-1:0] I_HS_A,
  input  logic [DW-1:0] I_HS_D,
  output logic          O_HS_ACK,
  output logic [DW-1:0] O_HS_Q,
  output logic [AW-1:0] O_RAM_A,
  output logic [DW-1:0] O_RAM_D,
  output logic          O_RAM_CE,
  output logic          O_RAM_WE,
  input  logic [DW-1:0] I_RAM_Q,
  output logic [DW-1:0] O_TILE,
  output logic          O_TILE_VLD
);

  arb_state_t    state;
  logic          strobe, strobe_q, cpu_edge, cpu_pend, cpu_req;
  logic          vid_slot, next_slot, cpu_free, hs_prio, hs_win, cpu_win;
  logic          rd_cap, hs_rd, tile_cap;
  logic [DW-1:0] db_q, hs_q, tile_q;

  assign strobe   = I_VRAM_RDn & I_VRAM_WRn;
  assign cpu_edge = strobe_q & ~strobe;
  assign cpu_req  = cpu_edge | cpu_pend;

  assign vid_slot  = I_CMPBLK && (I_H_CNT[3:0] == VID_SLOT);
  // Grants are decided one cycle before the access, so a grant is withheld
  // when the following cycle belongs to the video fetch.
  assign next_slot = I_CMPBLK && (I_H_CNT[3:0] == VID_SLOT - 4'd1);
  assign cpu_free  = !next_slot && (!CPU_BLOCK_DISP || !I_CMPBLK);

  assign hs_win  = (state == IDLE) && I_HS_REQ && !next_slot &&
                   (hs_prio || !(cpu_req && cpu_free));
  assign cpu_win = (state == IDLE) && cpu_req && cpu_free && !hs_win;

  dkongjr_arb_age #(
    .MAX (4'(HS_MAX_WAIT))
  ) u_age (
    .clk    (CLK_12M),
    .rst    (I_RESET),
    .clr    (hs_win || !I_HS_REQ),
    .inc    (cpu_win && I_HS_REQ),
    .at_max (hs_prio)
  );

  always_ff @(posedge CLK_12M) begin
    if (I_RESET) begin
      state    <= IDLE;
      strobe_q <= 1'b1;
      cpu_pend <= 1'b0;
      rd_cap   <= 1'b0;
      hs_rd    <= 1'b0;
      tile_cap <= 1'b0;
      db_q     <= '0;
      hs_q     <= '0;
      tile_q   <= '0;
    end else begin
      strobe_q <= strobe;
      cpu_pend <= cpu_req && !cpu_win;
      tile_cap <= vid_slot;
      rd_cap   <= 1'b0;
      if (tile_cap) tile_q <= I_RAM_Q;
      if (rd_cap)   db_q   <= I_RAM_Q;
      case (state)
        IDLE: begin
          if (hs_win)       state <= HS_ISSUE;
          else if (cpu_win) state <= CPU_ISSUE;
        end
        CPU_ISSUE: begin
          rd_cap <= I_VRAM_WRn;          // write wins when both strobes are low
          state  <= CPU_DONE;
        end
        CPU_DONE: begin
          if (strobe) state <= IDLE;     // one access per strobe
        end
        HS_ISSUE: begin
          hs_rd <= ~I_HS_WE;
          state <= HS_DONE;
        end
        HS_DONE: begin
          if (hs_rd) hs_q <= I_RAM_Q;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM pins follow the current state; reset drops them so an access caught
  // by reset never writes.
  always_comb begin
    O_RAM_CE = 1'b0;
    O_RAM_WE = 1'b0;
    O_RAM_A  = '0;
    O_RAM_D  = '0;
    if (!I_RESET) begin
      if (vid_slot) begin
        O_RAM_CE = 1'b1;
        O_RAM_A  = vid_addr(I_VF_CNT, I_H_CNT, I_FLIP);
      end else if (state == CPU_ISSUE) begin
        O_RAM_CE = 1'b1;
        O_RAM_WE = ~I_VRAM_WRn;
        O_RAM_A  = I_AB;
        O_RAM_D  = I_DB;
      end else if (state == HS_ISSUE) begin
        O_RAM_CE = 1'b1;
        O_RAM_WE = I_HS_WE;
        O_RAM_A  = I_HS_A;
        O_RAM_D  = I_HS_D;
      end
    end
  end

  // Read data is passed straight through in the cycle it returns from the
  // RAM and held from the capture register afterwards.
  assign O_CPU_WAITn = I_RESET || !(cpu_req || (state == CPU_ISSUE));
  assign O_DB        = I_RESET ? '0 : (rd_cap ? I_RAM_Q : db_q);
  assign O_HS_ACK    = !I_RESET && (state == HS_DONE);
  assign O_HS_Q      = I_RESET ? '0 : ((state == HS_DONE && hs_rd) ? I_RAM_Q : hs_q);
  assign O_TILE_VLD  = !I_RESET && tile_cap;
  assign O_TILE      = I_RESET ? '0 : (tile_cap ? I_RAM_Q : tile_q);

endmodule

// File: tb/tb_dkongjr_vram_arb.sv
// Directed bench for dkongjr_vram_arb with a behavioural 1Kx8 synchronous RAM.
// Inputs change 1 time unit after posedge; outputs are checked on negedge.
module tb_dkongjr_vram_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, flip, cmpblk, wr_n, rd_n, hs_req, hs_we;
  logic [9:0] h_cnt, ab, hs_a;
  logic [7:0] vf_cnt, db, hs_d;
  logic [7:0] o_db, hs_q, ram_d, ram_q, tile;
  logic [9:0] ram_a;
  logic       wait_n, hs_ack, ram_ce, ram_we, tile_vld;

  logic [7:0] mem [0:1023];
  logic       pre_we;
  logic [9:0] pre_a;
  logic [7:0] pre_d;
  int wr_cnt = 0;
  int base_wr;
  int n_tests = 0;
  int n_fail = 0;

  dkongjr_vram_arb dut (
    .CLK_12M(clk), .I_RESET(rst), .I_H_CNT(h_cnt), .I_VF_CNT(vf_cnt),
    .I_FLIP(flip), .I_CMPBLK(cmpblk), .I_AB(ab), .I_DB(db),
    .I_VRAM_WRn(wr_n), .I_VRAM_RDn(rd_n), .O_DB(o_db), .O_CPU_WAITn(wait_n),
    .I_HS_REQ(hs_req), .I_HS_WE(hs_we), .I_HS_A(hs_a), .I_HS_D(hs_d),
    .O_HS_ACK(hs_ack), .O_HS_Q(hs_q), .O_RAM_A(ram_a), .O_RAM_D(ram_d),
    .O_RAM_CE(ram_ce), .O_RAM_WE(ram_we), .I_RAM_Q(ram_q),
    .O_TILE(tile), .O_TILE_VLD(tile_vld)
  );

  // External VRAM: address sampled on posedge, data out the following cycle.
  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_a] <= pre_d;
    end else if (ram_ce) begin
      if (ram_we) begin
        mem[ram_a] <= ram_d;
        wr_cnt     <= wr_cnt + 1;
      end
      ram_q <= mem[ram_a];
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk10(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    h_cnt = h_cnt + 10'd1;
  endtask

  task automatic preload(input logic [9:0] a, input logic [7:0] d);
    pre_a  = a;
    pre_d  = d;
    pre_we = 1'b1;
    cyc();
    pre_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; h_cnt = '0; vf_cnt = 8'h50; flip = 1'b0; cmpblk = 1'b0;
    ab = '0; db = '0; wr_n = 1'b1; rd_n = 1'b1;
    hs_req = 1'b0; hs_we = 1'b0; hs_a = '0; hs_d = '0;
    pre_we = 1'b0; pre_a = '0; pre_d = '0;

    // Reset and RAM preload
    preload(10'h14A, 8'h77);
    preload(10'h155, 8'h99);
    preload(10'h14B, 8'hB4);
    preload(10'h200, 8'hC3);
    preload(10'h050, 8'h11);
    @(negedge clk);
    chk1 ("rst_waitn",   wait_n,   1'b1);
    chk8 ("rst_db",      o_db,     8'h00);
    chk8 ("rst_tile",    tile,     8'h00);
    chk1 ("rst_tilevld", tile_vld, 1'b0);
    chk1 ("rst_hsack",   hs_ack,   1'b0);
    chk8 ("rst_hsq",     hs_q,     8'h00);
    chk1 ("rst_ce",      ram_ce,   1'b0);
    chk1 ("rst_we",      ram_we,   1'b0);
    chk10("rst_a",       ram_a,    10'h000);
    chk8 ("rst_d",       ram_d,    8'h00);
    chk32("rst_age",     int'(dut.u_age.cnt), 0);
    cyc(); rst = 1'b0;
    cyc();

    // CPU write 5A to 123 in blank
    cyc(); ab = 10'h123; db = 8'h5A; wr_n = 1'b0;
    @(negedge clk); chk1("wr_det_waitn", wait_n, 1'b0);
    cyc(); @(negedge clk);
    chk1 ("wr_iss_waitn", wait_n, 1'b0);
    chk1 ("wr_iss_ce",    ram_ce, 1'b1);
    chk1 ("wr_iss_we",    ram_we, 1'b1);
    chk10("wr_iss_a",     ram_a,  10'h123);
    chk8 ("wr_iss_d",     ram_d,  8'h5A);
    cyc(); @(negedge clk);
    chk1 ("wr_done_waitn", wait_n, 1'b1);
    chk1 ("wr_done_we",    ram_we, 1'b0);
    chk8 ("wr_mem",        mem[10'h123], 8'h5A);
    cyc(); wr_n = 1'b1;
    cyc();

    // CPU read back from 123
    cyc(); rd_n = 1'b0;
    @(negedge clk); chk1("rd_det_waitn", wait_n, 1'b0);
    cyc(); @(negedge clk);
    chk1 ("rd_iss_waitn", wait_n, 1'b0);
    chk1 ("rd_iss_we",    ram_we, 1'b0);
    chk10("rd_iss_a",     ram_a,  10'h123);
    cyc(); @(negedge clk);
    chk1 ("rd_done_waitn", wait_n, 1'b1);
    chk8 ("rd_data",       o_db,   8'h5A);
    cyc(); @(negedge clk);
    chk8 ("rd_data_held",  o_db,   8'h5A);
    cyc(); rd_n = 1'b1;
    cyc();

    // Video fetch, FLIP=0: VF=50, H=0AC -> A=14A
    cyc(); cmpblk = 1'b1; h_cnt = 10'h0AB;
    @(negedge clk); chk1("vid_pre_ce", ram_ce, 1'b0);
    cyc(); @(negedge clk);
    chk1 ("vid_ce",   ram_ce, 1'b1);
    chk1 ("vid_we",   ram_we, 1'b0);
    chk10("vid_a",    ram_a,  10'h14A);
    cyc(); @(negedge clk);
    chk1 ("vid_vld",  tile_vld, 1'b1);
    chk8 ("vid_tile", tile,     8'h77);
    cyc(); @(negedge clk);
    chk1 ("vid_vld_end",  tile_vld, 1'b0);
    chk8 ("vid_tile_hold", tile,    8'h77);

    // Video fetch, FLIP=1 -> A=155
    cyc(); flip = 1'b1; h_cnt = 10'h0AB;
    cyc(); @(negedge clk);
    chk10("vidf_a", ram_a, 10'h155);
    cyc(); @(negedge clk);
    chk1 ("vidf_vld",  tile_vld, 1'b1);
    chk8 ("vidf_tile", tile,     8'h99);

    // HS request whose issue would land on the slot: deferred one cycle
    cyc(); flip = 1'b0; h_cnt = 10'h0BB; hs_req = 1'b1; hs_a = 10'h200; hs_we = 1'b0;
    @(negedge clk); chk1("hsd_pre_ce", ram_ce, 1'b0);
    cyc(); @(negedge clk);
    chk10("hsd_slot_a",   ram_a,  10'h14B);
    chk1 ("hsd_slot_we",  ram_we, 1'b0);
    chk1 ("hsd_slot_ack", hs_ack, 1'b0);
    cyc(); @(negedge clk);
    chk1 ("hsd_iss_ce",  ram_ce,   1'b1);
    chk10("hsd_iss_a",   ram_a,    10'h200);
    chk1 ("hsd_tile_vld", tile_vld, 1'b1);
    chk8 ("hsd_tile",    tile,     8'hB4);
    cyc(); hs_req = 1'b0; @(negedge clk);
    chk1 ("hsd_ack", hs_ack, 1'b1);
    chk8 ("hsd_q",   hs_q,   8'hC3);
    cyc(); @(negedge clk);
    chk1 ("hsd_ack_end", hs_ack, 1'b0);
    chk8 ("hsd_q_hold",  hs_q,   8'hC3);

    // CPU read during display is held off until blank
    cyc(); ab = 10'h200; rd_n = 1'b0;
    @(negedge clk); chk1("blk_det_waitn", wait_n, 1'b0);
    for (int i = 0; i < 20; i++) cyc();
    @(negedge clk); chk1("blk_hold_waitn", wait_n, 1'b0);
    cyc(); cmpblk = 1'b0;
    @(negedge clk); chk1("blk_fall_waitn", wait_n, 1'b0);
    cyc(); @(negedge clk);
    chk1 ("blk_iss_waitn", wait_n, 1'b0);
    chk10("blk_iss_a",     ram_a,  10'h200);
    cyc(); @(negedge clk);
    chk1 ("blk_done_waitn", wait_n, 1'b1);
    chk8 ("blk_data",       o_db,   8'hC3);
    cyc(); rd_n = 1'b1;
    cyc();

    // CPU and HS both pending: CPU wins 8 times, then HS is promoted
    ab = 10'h123; hs_a = 10'h123; hs_we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(); rd_n = 1'b0; hs_req = 1'b1;
      @(negedge clk); chk1("age_cpu_waitn", wait_n, 1'b0);
      cyc();
      cyc(); rd_n = 1'b1;
      @(negedge clk);
      chk1("age_cpu_noack", hs_ack, 1'b0);
      chk8("age_cpu_data",  o_db,   8'h5A);
    end
    chk32("age_at_max", int'(dut.u_age.cnt), 8);
    cyc(); rd_n = 1'b0;
    @(negedge clk); chk1("age_hs_waitn", wait_n, 1'b0);
    cyc(); @(negedge clk);
    chk1 ("age_hs_iss_ce",    ram_ce, 1'b1);
    chk10("age_hs_iss_a",     ram_a,  10'h123);
    chk1 ("age_hs_iss_waitn", wait_n, 1'b0);
    chk32("age_cleared",      int'(dut.u_age.cnt), 0);
    cyc(); hs_req = 1'b0; @(negedge clk);
    chk1("age_hs_ack", hs_ack, 1'b1);
    chk8("age_hs_q",   hs_q,   8'h5A);
    cyc(); @(negedge clk);
    chk1("age_cpu2_waitn", wait_n, 1'b0);
    chk1("age_cpu2_noack", hs_ack, 1'b0);
    cyc(); @(negedge clk);
    chk1("age_cpu2_iss", ram_ce, 1'b1);
    cyc(); @(negedge clk);
    chk1("age_cpu2_done_waitn", wait_n, 1'b1);
    cyc(); rd_n = 1'b1;
    cyc();

    // Reset during a CPU write issue: no write, restart after release
    cyc(); ab = 10'h050; db = 8'hEE; wr_n = 1'b0;
    @(negedge clk);
    base_wr = wr_cnt;
    chk1("rstw_det_waitn", wait_n, 1'b0);
    cyc(); rst = 1'b1;
    @(negedge clk);
    chk1("rstw_we",    ram_we, 1'b0);
    chk1("rstw_ce",    ram_ce, 1'b0);
    chk1("rstw_waitn", wait_n, 1'b1);
    cyc(); rst = 1'b0;
    @(negedge clk);
    chk32("rstw_nowrite", wr_cnt, base_wr);
    chk8 ("rstw_mem_old", mem[10'h050], 8'h11);
    chk8 ("rstw_db_zero", o_db, 8'h00);
    chk1 ("rstw_new_waitn", wait_n, 1'b0);
    cyc(); @(negedge clk);
    chk1 ("rstw_iss_we", ram_we, 1'b1);
    chk10("rstw_iss_a",  ram_a,  10'h050);
    chk8 ("rstw_iss_d",  ram_d,  8'hEE);
    cyc(); wr_n = 1'b1;
    @(negedge clk);
    chk1("rstw_done_waitn", wait_n, 1'b1);
    cyc(); @(negedge clk);
    chk8 ("rstw_mem_new", mem[10'h050], 8'hEE);
    chk32("rstw_one_write", wr_cnt, base_wr + 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
